pmu_rail_ctrl: RTL and testbench

Parametrised command-driven controller for PMU power rails over I2C, sitting between the ICE bus-side command decoder and the `pmu_i2c` byte engine. It generalises rail count, device address and register map, and serialises enable and voltage writes and reads into I2C byte sequences. Voltage writes add an automatic slew-register write. Results return as one ACK/NAK response with read data. Enable state is kept in a shadow register that is committed only on a successful transaction.

---
 rtl/pmu_rail_pkg.sv | 26 ++
 rtl/pmu_rail_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_pmu_rail_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmu_rail_pkg.sv
// Shared types and constants for the PMU rail controller.
package pmu_rail_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StCheck,
    StAddr,
    StSub,
    StData,
    StRaddr,
    StRdata,
    StDone,
    StNext,
    StResp
  } pmu_state_e;

  localparam logic PMU_WR       = 1'b0;
  localparam logic PMU_RD       = 1'b1;
  localparam logic PMU_PARAM_EN = 1'b0;
  localparam logic PMU_PARAM_V  = 1'b1;

  function automatic int unsigned retry_cnt_w(int unsigned max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/pmu_rail_ctrl.sv
// Command-driven PMU rail controller that serialises enable/voltage accesses into I2C bytes.
// Define PMU_RAIL_RETRY_EN to retry failed transactions up to MAX_RETRY times.
module pmu_rail_ctrl
  import pmu_rail_pkg::*;
#(
  parameter int unsigned NUM_RAILS    = 4,
  parameter logic [6:0]  DEV_ADDR     = 7'h34,
  parameter logic [7:0]  EN_SUBADDR   = 8'h10,
  parameter logic [7:0]  EN_FIXED     = 8'h80,
  parameter logic [7:0]  DAC_BASE     = 8'h23,
  parameter logic [7:0]  DAC_STRIDE   = 8'h03,
  parameter logic [7:0]  SLEW_SUBADDR = 8'h20,
  parameter logic [7:0]  SLEW_VAL     = 8'h55,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_rd,
  input  logic                 cmd_param,
  input  logic [2:0]           cmd_idx,
  input  logic [7:0]           cmd_val,
  output logic                 rsp_valid,
  output logic                 rsp_ack,
  output logic [7:0]           rsp_data,
  output logic [NUM_RAILS-1:0] en_shadow,
  output logic [7:0]           i2c_data,
  output logic                 i2c_start,
  output logic                 i2c_done,
  output logic                 i2c_rw,
  output logic                 i2c_clear_failed,
  input  logic                 i2c_data_latch,
  input  logic                 i2c_ready,
  input  logic                 i2c_failed,
  input  logic                 i2c_rd_valid,
  input  logic [7:0]           i2c_rd_data
);

  localparam int unsigned RetryW = retry_cnt_w(MAX_RETRY);
`ifdef PMU_RAIL_RETRY_EN
  localparam logic [RetryW-1:0] RetryLimit = RetryW'(MAX_RETRY);
`else
  localparam logic [RetryW-1:0] RetryLimit = '0;
`endif

  pmu_state_e state_q, state_d;
  logic                 rd_q, rd_d;
  logic                 param_q, param_d;
  logic [2:0]           idx_q, idx_d;
  logic [4:0]           val_q, val_d;
  logic                 seg_q, seg_d;
  logic                 ack_q, ack_d;
  logic [7:0]           rd_byte_q, rd_byte_d;
  logic [RetryW-1:0]    retry_q, retry_d;
  logic [NUM_RAILS-1:0] en_shadow_q, en_shadow_d;

  logic       idx_ok;
  logic       last_seg;
  logic [7:0] sub_addr;
  logic [7:0] wr_byte;
  logic [7:0] en_byte;
  logic [7:0] rd_result;
  logic       unused_val_bits;

  assign unused_val_bits = ^cmd_val[7:5];
  assign en_shadow       = en_shadow_q;

  assign idx_ok   = (32'(idx_q) < NUM_RAILS);
  assign last_seg = seg_q || (rd_q == PMU_WR && param_q == PMU_PARAM_EN);

  // Enable byte: fixed upper bits, committed rail bits, target rail replaced.
  always_comb begin
    en_byte = EN_FIXED;
    for (int i = 0; i < int'(NUM_RAILS); i++) begin
      en_byte[i] = (idx_q == 3'(i)) ? val_q[0] : en_shadow_q[i];
    end
  end

  always_comb begin
    if (param_q == PMU_PARAM_EN) begin
      sub_addr = EN_SUBADDR;
      wr_byte  = en_byte;
    end else if (seg_q) begin
      sub_addr = SLEW_SUBADDR;
      wr_byte  = SLEW_VAL;
    end else begin
      sub_addr = DAC_BASE + 8'(idx_q) * DAC_STRIDE;
      wr_byte  = {3'b000, val_q};
    end
  end

  assign rd_result = (param_q == PMU_PARAM_V) ? rd_byte_q : {7'b0, rd_byte_q[idx_q]};

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    param_d     = param_q;
    idx_d       = idx_q;
    val_d       = val_q;
    seg_d       = seg_q;
    ack_d       = ack_q;
    rd_byte_d   = rd_byte_q;
    retry_d     = retry_q;
    en_shadow_d = en_shadow_q;

    cmd_ready        = 1'b0;
    rsp_valid        = 1'b0;
    rsp_ack          = 1'b0;
    rsp_data         = 8'h00;
    i2c_data         = 8'h00;
    i2c_start        = 1'b0;
    i2c_done         = 1'b0;
    i2c_rw           = 1'b0;
    i2c_clear_failed = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          rd_d      = cmd_rd;
          param_d   = cmd_param;
          idx_d     = cmd_idx;
          val_d     = cmd_val[4:0];
          ack_d     = 1'b0;
          rd_byte_d = 8'h00;
          retry_d   = '0;
          state_d   = StCheck;
        end
      end
      StCheck: begin
        seg_d = 1'b0;
        if (idx_ok) begin
          state_d = StAddr;
        end else begin
          ack_d   = 1'b0;
          state_d = StResp;
        end
      end
      StAddr: begin
        i2c_start = 1'b1;
        i2c_rw    = 1'b1;
        i2c_data  = {DEV_ADDR, 1'b0};
        if (i2c_data_latch) state_d = StSub;
      end
      StSub: begin
        i2c_rw   = 1'b1;
        i2c_data = sub_addr;
        if (i2c_data_latch) state_d = (rd_q == PMU_RD) ? StDone : StData;
      end
      StData: begin
        i2c_rw   = 1'b1;
        i2c_data = wr_byte;
        if (i2c_data_latch) state_d = StDone;
      end
      StRaddr: begin
        i2c_start = 1'b1;
        i2c_rw    = 1'b1;
        i2c_data  = {DEV_ADDR, 1'b1};
        if (i2c_data_latch) state_d = StRdata;
      end
      StRdata: begin
        if (i2c_rd_valid) begin
          rd_byte_d = i2c_rd_data;
          state_d   = StDone;
        end
      end
      StDone: begin
        i2c_done = 1'b1;
        if (i2c_ready) begin
          if (i2c_failed) begin
            if (retry_q < RetryLimit) begin
              i2c_clear_failed = 1'b1;
              retry_d          = retry_q + RetryW'(1);
              seg_d            = 1'b0;
              state_d          = StAddr;
            end else begin
              ack_d   = 1'b0;
              state_d = StResp;
            end
          end else if (last_seg) begin
            ack_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StNext;
          end
        end
      end
      StNext: begin
        seg_d   = 1'b1;
        state_d = (rd_q == PMU_RD) ? StRaddr : StAddr;
      end
      StResp: begin
        rsp_valid        = 1'b1;
        rsp_ack          = ack_q;
        rsp_data         = (ack_q && rd_q == PMU_RD) ? rd_result : 8'h00;
        i2c_clear_failed = 1'b1;
        if (ack_q && rd_q == PMU_WR && param_q == PMU_PARAM_EN) begin
          for (int i = 0; i < int'(NUM_RAILS); i++) begin
            if (idx_q == 3'(i)) en_shadow_d[i] = val_q[0];
          end
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs stay quiet for the whole reset window, even before the state register clears.
    if (reset) begin
      cmd_ready        = 1'b0;
      rsp_valid        = 1'b0;
      rsp_ack          = 1'b0;
      rsp_data         = 8'h00;
      i2c_data         = 8'h00;
      i2c_start        = 1'b0;
      i2c_done         = 1'b0;
      i2c_rw           = 1'b0;
      i2c_clear_failed = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_q        <= 1'b0;
      param_q     <= 1'b0;
      idx_q       <= 3'd0;
      val_q       <= 5'd0;
      seg_q       <= 1'b0;
      ack_q       <= 1'b0;
      rd_byte_q   <= 8'h00;
      retry_q     <= '0;
      en_shadow_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      param_q     <= param_d;
      idx_q       <= idx_d;
      val_q       <= val_d;
      seg_q       <= seg_d;
      ack_q       <= ack_d;
      rd_byte_q   <= rd_byte_d;
      retry_q     <= retry_d;
      en_shadow_q <= en_shadow_d;
    end
  end

endmodule

// File: tb/tb_pmu_rail_ctrl.sv
// Scoreboard bench for pmu_rail_ctrl: a behavioural I2C engine checks bytes, a monitor checks responses.
module tb_pmu_rail_ctrl;

`ifdef PMU_RAIL_RETRY_EN
  localparam int Attempts = 4;
`else
  localparam int Attempts = 1;
`endif

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rd;
  logic       cmd_param;
  logic [2:0] cmd_idx;
  logic [7:0] cmd_val;
  logic       rsp_valid;
  logic       rsp_ack;
  logic [7:0] rsp_data;
  logic [3:0] en_shadow;
  logic [7:0] i2c_data;
  logic       i2c_start;
  logic       i2c_done;
  logic       i2c_rw;
  logic       i2c_clear_failed;
  logic       i2c_data_latch;
  logic       i2c_ready;
  logic       i2c_failed;
  logic       i2c_rd_valid;
  logic [7:0] i2c_rd_data;

  pmu_rail_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_rd           (cmd_rd),
    .cmd_param        (cmd_param),
    .cmd_idx          (cmd_idx),
    .cmd_val          (cmd_val),
    .rsp_valid        (rsp_valid),
    .rsp_ack          (rsp_ack),
    .rsp_data         (rsp_data),
    .en_shadow        (en_shadow),
    .i2c_data         (i2c_data),
    .i2c_start        (i2c_start),
    .i2c_done         (i2c_done),
    .i2c_rw           (i2c_rw),
    .i2c_clear_failed (i2c_clear_failed),
    .i2c_data_latch   (i2c_data_latch),
    .i2c_ready        (i2c_ready),
    .i2c_failed       (i2c_failed),
    .i2c_rd_valid     (i2c_rd_valid),
    .i2c_rd_data      (i2c_rd_data)
  );

  typedef struct {
    logic       ack;
    logic [7:0] data;
    int         lat;
    int         acc;
  } rsp_t;

  rsp_t       rsp_q[$];
  logic [8:0] exp_bytes[$];

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   rsp_seen  = 0;
  int   bytes_seen = 0;
  int   start_cnt = 0;
  logic fail_mode = 1'b0;
  logic [7:0] rd_ret = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic log_byte(input logic [8:0] got);
    bytes_seen++;
    if (exp_bytes.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL i2c_byte: got %0h, required no traffic", got);
    end else begin
      check("i2c_byte", 32'(got), 32'(exp_bytes.pop_front()));
    end
  endtask

  task automatic push_wr(input logic [7:0] sub, input logic [7:0] data);
    exp_bytes.push_back(9'h068);
    exp_bytes.push_back({1'b0, sub});
    exp_bytes.push_back({1'b0, data});
  endtask

  task automatic push_rd(input logic [7:0] sub);
    exp_bytes.push_back(9'h068);
    exp_bytes.push_back({1'b0, sub});
    exp_bytes.push_back(9'h069);
    exp_bytes.push_back(9'h100);
  endtask

  // Behavioural byte engine: every byte state is held two cycles before it is latched.
  initial begin
    logic gap;
    logic active;
    gap = 1'b0;
    active = 1'b0;
    i2c_data_latch = 1'b0;
    i2c_ready = 1'b0;
    i2c_failed = 1'b0;
    i2c_rd_valid = 1'b0;
    i2c_rd_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      i2c_data_latch = 1'b0;
      i2c_rd_valid   = 1'b0;
      i2c_ready      = 1'b0;
      i2c_failed     = 1'b0;
      if (reset) begin
        active = 1'b0;
        gap    = 1'b0;
      end else if (gap) begin
        gap = 1'b0;
      end else if (i2c_done) begin
        i2c_ready  = 1'b1;
        i2c_failed = fail_mode;
        active     = 1'b0;
        gap        = 1'b1;
      end else if (i2c_start || (active && i2c_rw)) begin
        if (i2c_start) begin
          active = 1'b1;
          start_cnt++;
        end
        log_byte({1'b0, i2c_data});
        i2c_data_latch = 1'b1;
        gap = 1'b1;
      end else if (active) begin
        i2c_rd_data  = rd_ret;
        i2c_rd_valid = 1'b1;
        log_byte(9'h100);
        gap = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_t e;
      rsp_seen++;
      if (rsp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1, required no response");
      end else begin
        e = rsp_q.pop_front();
        check("rsp_ack", 32'(rsp_ack), 32'(e.ack));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_clear_failed", 32'(i2c_clear_failed), 32'd1);
        if (e.lat > 0) check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic rd, input logic prm, input logic [2:0] idx,
                       input logic [7:0] val, input logic want_rsp, input logic exp_ack,
                       input logic [7:0] exp_data, input int lat);
    int base;
    int n;
    base = rsp_seen;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_rd    = rd;
    cmd_param = prm;
    cmd_idx   = idx;
    cmd_val   = val;
    if (want_rsp) rsp_q.push_back('{ack: exp_ack, data: exp_data, lat: lat, acc: cyc});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (want_rsp) begin
      n = 0;
      while (rsp_seen == base && n < 400) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("rsp_arrived", 32'(rsp_seen != base), 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_rd = 1'b0;
    cmd_param = 1'b0;
    cmd_idx = 3'd0;
    cmd_val = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_en_shadow", 32'(en_shadow), 32'd0);
    check("reset_i2c_start", 32'(i2c_start), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

    // Enable write, rail 2 on.
    push_wr(8'h10, 8'h84);
    issue(1'b0, 1'b0, 3'd2, 8'h01, 1'b1, 1'b1, 8'h00, 0);
    check("shadow_after_en2", 32'(en_shadow), 32'h4);

    // Voltage write with automatic slew write.
    push_wr(8'h26, 8'h1F);
    push_wr(8'h20, 8'h55);
    issue(1'b0, 1'b1, 3'd1, 8'h1F, 1'b1, 1'b1, 8'h00, 0);
    check("shadow_after_vwr", 32'(en_shadow), 32'h4);

    // Reads.
    rd_ret = 8'h12;
    push_rd(8'h2C);
    issue(1'b1, 1'b1, 3'd3, 8'h00, 1'b1, 1'b1, 8'h12, 0);
    rd_ret = 8'h01;
    push_rd(8'h10);
    issue(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 8'h01, 0);
    rd_ret = 8'h04;
    push_rd(8'h10);
    issue(1'b1, 1'b0, 3'd2, 8'h00, 1'b1, 1'b1, 8'h01, 0);
    rd_ret = 8'hFD;
    push_rd(8'h10);
    issue(1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b1, 8'h00, 0);

    // Out-of-range rail: NAK without bus traffic.
    base = start_cnt;
    issue(1'b0, 1'b0, 3'd5, 8'h01, 1'b1, 1'b0, 8'h00, 2);
    check("bad_idx_no_start", 32'(start_cnt - base), 32'd0);

    // Engine fails every attempt.
    fail_mode = 1'b1;
    base = start_cnt;
    for (int a = 0; a < Attempts; a++) push_wr(8'h10, 8'h85);
    issue(1'b0, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0, 8'h00, 0);
    fail_mode = 1'b0;
    check("fail_attempts", 32'(start_cnt - base), 32'(Attempts));
    check("shadow_after_fail", 32'(en_shadow), 32'h4);

    push_wr(8'h10, 8'h80);
    issue(1'b0, 1'b0, 3'd2, 8'h00, 1'b1, 1'b1, 8'h00, 0);
    check("shadow_after_en2_off", 32'(en_shadow), 32'h0);
    push_wr(8'h10, 8'h88);
    issue(1'b0, 1'b0, 3'd3, 8'h01, 1'b1, 1'b1, 8'h00, 0);
    check("shadow_after_en3", 32'(en_shadow), 32'h8);

    // Reset while the data byte is being presented.
    exp_bytes.push_back(9'h068);
    exp_bytes.push_back(9'h010);
    base = bytes_seen;
    issue(1'b0, 1'b0, 3'd1, 8'h01, 1'b0, 1'b0, 8'h00, 0);
    n = 0;
    while (bytes_seen < base + 2 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("reached_data_state", 32'(bytes_seen - base), 32'd2);
    @(posedge clk);
    @(negedge clk);
    check("data_byte_staged", 32'(i2c_data), 32'h8A);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_shadow", 32'(en_shadow), 32'h0);
    @(negedge clk);
    check("mid_reset_ready_after", 32'(cmd_ready), 32'd1);
    repeat (5) @(negedge clk);

    push_wr(8'h10, 8'h81);
    issue(1'b0, 1'b0, 3'd0, 8'h01, 1'b1, 1'b1, 8'h00, 0);
    check("shadow_after_reset_write", 32'(en_shadow), 32'h1);

    repeat (5) @(negedge clk);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("byte_queue_drained", 32'(exp_bytes.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
